sev_seg_decoder: RTL and testbench
==================================

# sev_seg_decoder

Receive-side companion to the BCD counter: samples the four 7-segment display buses the counter drives, rejects transient patterns, decodes each digit back to BCD, and sequentially converts the 4-digit decimal value to binary. It sits between the counter's `sev_seg0..3` outputs and any checker or logger that needs the displayed count as a number. Results are delivered with a one-cycle `valid` strobe and an `err` flag for undecodable segments.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive clock edges a pattern must be captured unchanged before it is decoded (legal range 1–255).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `sev_seg0` input 7: units digit segments. Active-low, bit0=a … bit6=g.
- `sev_seg1` input 7: tens digit, same encoding.
- `sev_seg2` input 7: hundreds digit, same encoding.
- `sev_seg3` input 7: thousands digit, same encoding.
- `bcd0`..`bcd3` output 4 each: decoded digits of the last successful conversion.
- `count` output 14: binary value 0–9999 of the last successful conversion.
- `valid` output 1: one-cycle strobe; `count` and `bcd*` updated in the same cycle.
- `err` output 1: last stable pattern contained an undecodable digit.

## Operation
- Legal codes (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
- Any other code, including blank 7F, is invalid.
- Capture: all 28 input bits registered every edge into `snap`.
- Stability counter: if `snap` equals the previous `snap`, it increments, saturating at `STABLE_CYCLES`. Otherwise it is set to 1.
- The pattern is stable once the counter reaches `STABLE_CYCLES`.
- FSM states:
  - WAIT → DECODE when the pattern is stable AND (no conversion done since reset OR `snap` ≠ `last_pat`).
  - DECODE (1 cycle): latch `snap` into `last_pat` and decode all four digits.
    - Any invalid digit: set `err=1`, leave `count`/`bcd*` unchanged, no `valid`, go to WAIT.
    - Otherwise go to CONVERT with `acc=0` and `i=3`.
  - CONVERT (4 cycles): `acc <= acc*10 + digit[i]`, i = 3,2,1,0. Implement `*10` as `(acc<<3)+(acc<<1)`; `acc` is 14 bits and never exceeds 9999.
  - DONE (1 cycle): load `count<=acc` and `bcd*` from the latched digits, `valid=1`, `err=0`, go to WAIT.
- Capture and the stability counter run continuously in every state.
- An input change during DECODE, CONVERT or DONE does not disturb the conversion in progress. The new pattern is handled from WAIT once it is stable.
- An unchanged pattern is never re-converted. The same pattern after an intervening different stable pattern is converted again.

## Timing
- Reset values (asserted asynchronously while `rst=0`):
  - outputs: `count`=0, `bcd0..3`=0, `valid`=0, `err`=0
  - internal: FSM=WAIT, stability counter=0, `snap`=0, "converted-since-reset" flag cleared
- Latency: new pattern first captured at edge E0, held steady thereafter.
  - DECODE entered at edge E0+S, where S=`STABLE_CYCLES`.
  - CONVERT runs at edges E0+S+1 … E0+S+4.
  - `valid` and outputs registered at edge E0+S+5 (E0+9 with the default).
  - `valid` is high for exactly one cycle.
- `err` is registered at edge E0+S+1. It stays set until the next successful DONE or reset.
- Reset mid-operation aborts any state immediately. After release, the held pattern is treated as new and converted.
- Maximum throughput: one conversion per S+6 cycles.

## Test plan
- **Reset:** hold `rst=0` with the inputs at digit 8 → `count`=0, `bcd`=0000, `valid`=0, `err`=0 throughout.
- **Basic conversion:** release reset, drive `sev_seg3..0` = 79,24,30,19 from edge E0 → single `valid` at E0+9, `count`=1234 (0x4D2), `bcd3..0`=1,2,3,4.
- **Glitch filter:** toggle `sev_seg0` between 40 and 79 every 2 cycles for 12 cycles, then hold 10,10,10,10 → no `valid` during the toggling. Exactly one `valid` 9 edges after the last change, with `count`=9999.
- **Invalid digit:** after 1234, drive `sev_seg2`=7F → `err`=1 at E0+5, no `valid`, `count` stays 1234. Then restore a legal 0000 (40×4) → `valid` with `count`=0 and `err` back to 0.
- **No repeat:** hold 5,0,0,7 (12,40,40,78) for 100 cycles → exactly one `valid` with `count`=5007. Switch to 0001 and then back to 5007 → one `valid` per change.
- **Reset mid-CONVERT:** assert `rst` two edges after DECODE → all outputs 0 immediately. Release with the pattern unchanged → `valid` S+5 edges after the first post-reset capture, `count` equal to the held value.

Source files
------------

// File: rtl/sev_seg_decoder.sv
// Seven-segment display reader: debounces four digit buses, decodes them
// to BCD and converts the 4-digit decimal value to binary sequentially.
module sev_seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sev_seg0,
  input  logic [6:0]  sev_seg1,
  input  logic [6:0]  sev_seg2,
  input  logic [6:0]  sev_seg3,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic [13:0] count,
  output logic        valid,
  output logic        err
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_DECODE,
    S_CONVERT,
    S_DONE
  } state_t;

  localparam logic [7:0] S_MAX = 8'(STABLE_CYCLES);

  // Returns {ok, digit}; ok is clear for any non-digit code.
  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'd0};
      7'h79:   r = {1'b1, 4'd1};
      7'h24:   r = {1'b1, 4'd2};
      7'h30:   r = {1'b1, 4'd3};
      7'h19:   r = {1'b1, 4'd4};
      7'h12:   r = {1'b1, 4'd5};
      7'h02:   r = {1'b1, 4'd6};
      7'h78:   r = {1'b1, 4'd7};
      7'h00:   r = {1'b1, 4'd8};
      7'h10:   r = {1'b1, 4'd9};
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  state_t          state;
  state_t          state_nx;
  logic [27:0]     pat;
  logic [27:0]     snap;
  logic [27:0]     last_pat;
  logic [7:0]      stab;
  logic            stable;
  logic            seen;
  logic [3:0][3:0] dv;
  logic [3:0]      dok;
  logic [3:0][3:0] dig;
  logic [13:0]     acc;
  logic [13:0]     acc_nx;
  logic [1:0]      idx;
  logic            do_decode;
  logic            do_step;
  logic            do_load;

  assign pat    = {sev_seg3, sev_seg2, sev_seg1, sev_seg0};
  assign stable = (stab == S_MAX);
  assign acc_nx = (acc << 3) + (acc << 1)
                + {10'd0, dig[idx]};

  always_comb begin
    dv  = '0;
    dok = '0;
    for (int i = 0; i < 4; i++) begin
      {dok[i], dv[i]} = seg_dec(snap[7*i +: 7]);
    end
  end

  // Capture and stability filter run in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= '0;
      stab <= '0;
    end else begin
      snap <= pat;
      if (pat != snap) begin
        stab <= 8'd1;
      end else if (!stable) begin
        stab <= stab + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_WAIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT: begin
        if (stable && (!seen || snap != last_pat)) begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nx = (&dok) ? S_CONVERT : S_WAIT;
      end
      S_CONVERT: begin
        if (idx == 2'd0) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_WAIT;
      end
    endcase
  end

  always_comb begin
    do_decode = (state == S_DECODE);
    do_step   = (state == S_CONVERT);
    do_load   = do_step && (idx == 2'd0);
  end

  // Outputs load on the final accumulate step so valid is
  // visible during the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pat <= '0;
      seen     <= 1'b0;
      dig      <= '0;
      acc      <= '0;
      idx      <= '0;
      count    <= '0;
      bcd0     <= '0;
      bcd1     <= '0;
      bcd2     <= '0;
      bcd3     <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= do_load;
      if (do_decode) begin
        last_pat <= snap;
        seen     <= 1'b1;
        dig      <= dv;
        acc      <= '0;
        idx      <= 2'd3;
        if (!(&dok)) begin
          err <= 1'b1;
        end
      end
      if (do_step) begin
        acc <= acc_nx;
        idx <= idx - 2'd1;
      end
      if (do_load) begin
        count <= acc_nx;
        bcd0  <= dig[0];
        bcd1  <= dig[1];
        bcd2  <= dig[2];
        bcd3  <= dig[3];
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_decoder.sv
// Bench for sev_seg_decoder: scoreboard of expected conversions
// plus per-scenario latency and flag checks.
module tb_sev_seg_decoder;

  logic        clk;
  logic        rst;
  logic [6:0]  sev_seg0;
  logic [6:0]  sev_seg1;
  logic [6:0]  sev_seg2;
  logic [6:0]  sev_seg3;
  logic [3:0]  bcd0;
  logic [3:0]  bcd1;
  logic [3:0]  bcd2;
  logic [3:0]  bcd3;
  logic [13:0] count;
  logic        valid;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int nvalid = 0;
  logic [29:0] sb[$];
  logic [6:0] segtab [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  sev_seg_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .sev_seg0(sev_seg0),
    .sev_seg1(sev_seg1),
    .sev_seg2(sev_seg2),
    .sev_seg3(sev_seg3),
    .bcd0(bcd0),
    .bcd1(bcd1),
    .bcd2(bcd2),
    .bcd3(bcd3),
    .count(count),
    .valid(valid),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [29:0] e;
    if (rst && valid) begin
      nvalid++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: valid with count=%0d, required no valid",
                 count);
      end else begin
        e = sb.pop_front();
        if ({count, bcd3, bcd2, bcd1, bcd0} !== e) begin
          n_bad++;
          $display("FAIL sb_result: got %h, required %h",
                   {count, bcd3, bcd2, bcd1, bcd0}, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input bit push);
    int d3, d2, d1, d0;
    d3 = (n / 1000) % 10;
    d2 = (n / 100) % 10;
    d1 = (n / 10) % 10;
    d0 = n % 10;
    sev_seg3 = segtab[d3];
    sev_seg2 = segtab[d2];
    sev_seg1 = segtab[d1];
    sev_seg0 = segtab[d0];
    if (push) begin
      sb.push_back({14'(n), 4'(d3), 4'(d2), 4'(d1), 4'(d0)});
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    sev_seg0 = 7'h00;
    sev_seg1 = 7'h00;
    sev_seg2 = 7'h00;
    sev_seg3 = 7'h00;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_cmp++;
      if ({count, bcd3, bcd2, bcd1, bcd0, valid, err} !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_outputs: got %h, required 0",
                 {count, bcd3, bcd2, bcd1, bcd0, valid, err});
      end
    end
  endtask

  task automatic test_basic;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1234, 1'b1);
    tick(9);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early: valid=%b, required 0 at E0+8", valid);
    end
    tick(1);
    n_cmp++;
    if (valid !== 1'b1 || count !== 14'd1234) begin
      n_bad++;
      $display("FAIL basic_e9: valid=%b count=%0d, required 1/1234",
               valid, count);
    end
    tick(1);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_strobe: valid=%b, required 0 at E0+10", valid);
    end
    tick(5);
  endtask

  task automatic test_glitch;
    int n0;
    n0 = nvalid;
    for (int k = 0; k < 6; k++) begin
      sev_seg0 = (k % 2 == 1) ? 7'h79 : 7'h40;
      tick(2);
    end
    n_cmp++;
    if (nvalid !== n0) begin
      n_bad++;
      $display("FAIL glitch_quiet: %0d valids, required 0", nvalid - n0);
    end
    drive(9999, 1'b1);
    tick(9);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_early: valid=%b, required 0", valid);
    end
    tick(1);
    n_cmp++;
    if (valid !== 1'b1 || count !== 14'd9999) begin
      n_bad++;
      $display("FAIL glitch_e9: valid=%b count=%0d, required 1/9999",
               valid, count);
    end
    tick(5);
  endtask

  task automatic test_invalid;
    int n0;
    drive(1234, 1'b1);
    tick(16);
    n0 = nvalid;
    sev_seg2 = 7'h7F;
    tick(5);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL inv_early: err=%b, required 0 at E0+4", err);
    end
    tick(1);
    n_cmp++;
    if (err !== 1'b1 || count !== 14'd1234) begin
      n_bad++;
      $display("FAIL inv_err: err=%b count=%0d, required 1/1234",
               err, count);
    end
    tick(10);
    n_cmp++;
    if (err !== 1'b1 || nvalid !== n0) begin
      n_bad++;
      $display("FAIL inv_hold: err=%b valids=%0d, required 1/0",
               err, nvalid - n0);
    end
    drive(0, 1'b1);
    tick(10);
    n_cmp++;
    if (valid !== 1'b1 || err !== 1'b0 || count !== 14'd0) begin
      n_bad++;
      $display("FAIL inv_recover: valid=%b err=%b count=%0d, required 1/0/0",
               valid, err, count);
    end
    tick(5);
  endtask

  task automatic test_no_repeat;
    int n0;
    n0 = nvalid;
    drive(5007, 1'b1);
    tick(100);
    n_cmp++;
    if (nvalid !== n0 + 1 || count !== 14'd5007) begin
      n_bad++;
      $display("FAIL norep_hold: valids=%0d count=%0d, required 1/5007",
               nvalid - n0, count);
    end
    drive(1, 1'b1);
    tick(14);
    drive(5007, 1'b1);
    tick(14);
    n_cmp++;
    if (nvalid !== n0 + 3 || count !== 14'd5007) begin
      n_bad++;
      $display("FAIL norep_back: valids=%0d count=%0d, required 3/5007",
               nvalid - n0, count);
    end
  endtask

  task automatic test_reset_mid;
    drive(1234, 1'b0);
    tick(7);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({count, bcd3, bcd2, bcd1, bcd0, valid, err} !== 32'd0) begin
      n_bad++;
      $display("FAIL midrst_clear: got %h, required 0",
               {count, bcd3, bcd2, bcd1, bcd0, valid, err});
    end
    tick(2);
    rst = 1'b1;
    sb.push_back({14'd1234, 4'd1, 4'd2, 4'd3, 4'd4});
    tick(9);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_early: valid=%b, required 0", valid);
    end
    tick(1);
    n_cmp++;
    if (valid !== 1'b1 || count !== 14'd1234) begin
      n_bad++;
      $display("FAIL midrst_conv: valid=%b count=%0d, required 1/1234",
               valid, count);
    end
    tick(5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_invalid();
    test_no_repeat();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
